// File: rtl/lsu_pkg.sv
// Shared FSM encoding, RISC-V funct3 codes and the legality check for the
// load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    MERGE  = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } lsuState_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Low two funct3 bits give the access size for both loads and stores.
  function automatic logic isIllegal(input logic isStore, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (isStore) bad = (f3 >= 3'd3);
    else         bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if ((f3[1:0] == 2'b01) && off[0])         bad = 1'b1;
    if ((f3[1:0] == 2'b10) && (off != 2'b00)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational lane select and sign/zero extension of a little-endian
// memory word for LB/LH/LW/LBU/LHU.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            byteOff,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] ext
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  always_comb begin
    byteVal = word[{byteOff, 3'b000} +: 8];
    halfVal = word[{byteOff[1], 4'b0000} +: 16];
    ext     = word;
    case (funct3)
      F3_LB:   ext = {{(DATA_WIDTH-8){byteVal[7]}}, byteVal};
      F3_LBU:  ext = {{(DATA_WIDTH-8){1'b0}}, byteVal};
      F3_LH:   ext = {{(DATA_WIDTH-16){halfVal[15]}}, halfVal};
      F3_LHU:  ext = {{(DATA_WIDTH-16){1'b0}}, halfVal};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: captures a core request, performs the memory
// access (read-modify-write for SB/SH) and pulses done, with fault on errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  req,
  input  logic                  isStore,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH+1:0] byteAddr,
  input  logic [DATA_WIDTH-1:0] storeData,
  output logic [DATA_WIDTH-1:0] loadData,
  output logic                  done,
  output logic                  fault,
  output logic                  stall,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  input  logic [DATA_WIDTH-1:0] memReadData
);

  lsuState_t state, nextState;

  logic                  capStore;
  logic [2:0]            capFunct3;
  logic [ADDR_WIDTH+1:0] capAddr;
  logic [DATA_WIDTH-1:0] capData;
  logic [DATA_WIDTH-1:0] mergeReg;
  logic [DATA_WIDTH-1:0] mergedWord;
  logic [DATA_WIDTH-1:0] alignOut;
  logic                  illegal;
  logic                  capIsSw;

  assign illegal    = isIllegal(isStore, funct3, byteAddr[1:0]);
  assign capIsSw    = capStore && (capFunct3 == F3_SW);
  assign memAddress = capAddr[ADDR_WIDTH+1:2];
  assign stall      = req & ~done;

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) uAlign (
    .funct3  (capFunct3),
    .byteOff (capAddr[1:0]),
    .word    (memReadData),
    .ext     (alignOut)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (req) nextState = illegal ? ERR : ACCESS;
      ACCESS:  nextState = (capStore && !capIsSw) ? MERGE : DONE;
      MERGE:   nextState = DONE;
      DONE:    nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Sub-word store: replace only the addressed lane of the word read in ACCESS.
  always_comb begin
    mergedWord = mergeReg;
    if (capFunct3 == F3_SB) mergedWord[{capAddr[1:0], 3'b000} +: 8]  = capData[7:0];
    else                    mergedWord[{capAddr[1], 4'b0000} +: 16] = capData[15:0];
  end

  always_comb begin
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memWriteData = '0;
    done         = 1'b0;
    fault        = 1'b0;
    case (state)
      ACCESS: begin
        if (capIsSw) begin
          memWrite     = 1'b1;
          memWriteData = capData;
        end else begin
          memRead = 1'b1;
        end
      end
      MERGE: begin
        memWrite     = 1'b1;
        memWriteData = mergedWord;
      end
      DONE: done = 1'b1;
      ERR: begin
        done  = 1'b1;
        fault = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      capStore  <= 1'b0;
      capFunct3 <= '0;
      capAddr   <= '0;
      capData   <= '0;
      mergeReg  <= '0;
      loadData  <= '0;
    end else begin
      if (state == IDLE && req) begin
        capStore  <= isStore;
        capFunct3 <= funct3;
        capAddr   <= byteAddr;
        capData   <= storeData;
      end
      if (state == ACCESS) begin
        if (!capStore)    loadData <= alignOut;
        else if (!capIsSw) mergeReg <= memReadData;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-array memory, a reference
// memory/load model and a per-cycle protocol monitor.
module tb_load_store_unit;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clock = 1'b0;
  logic        resetn, req, isStore;
  logic [2:0]  funct3;
  logic [7:0]  byteAddr;
  logic [31:0] storeData, loadData, memWriteData, memReadData;
  logic        done, fault, stall, memRead, memWrite;
  logic [5:0]  memAddress;

  int          checks = 0;
  int          errors = 0;
  int          rdCnt = 0;
  int          wrCnt = 0;
  logic [31:0] modelLoad = 32'h0;
  logic [31:0] mem     [64];
  logic [31:0] initMem [64];
  logic [31:0] refMem  [64];
  logic        memLoad;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .req          (req),
    .isStore      (isStore),
    .funct3       (funct3),
    .byteAddr     (byteAddr),
    .storeData    (storeData),
    .loadData     (loadData),
    .done         (done),
    .fault        (fault),
    .stall        (stall),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memReadData  (memReadData)
  );

  always #5 clock = ~clock;

  assign memReadData = mem[memAddress];

  always @(posedge clock) begin
    if (memLoad) begin
      for (int i = 0; i < 64; i++) mem[i] <= initMem[i];
    end else if (memWrite) begin
      mem[memAddress] <= memWriteData;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Protocol rules that hold on every cycle.
  always @(negedge clock) begin
    chkb("stall", stall, req & ~done);
    chkb("rdWrExclusive", memRead & memWrite, 1'b0);
    chkb("strobeInDone", (memRead | memWrite) & done, 1'b0);
    chkb("faultWithoutDone", fault & ~done, 1'b0);
    chk("loadDataHold", loadData, modelLoad);
    if (memRead)  rdCnt++;
    if (memWrite) wrCnt++;
  end

  function automatic logic illegalOp(input logic st, input logic [2:0] f3, input logic [1:0] off);
    if (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if (st && f3 >= 3'd3) return 1'b1;
    if ((f3 == LH || f3 == LHU) && off[0]) return 1'b1;
    if (f3 == LW && off != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f3)
      LB:      return 32'($signed(s[7:0]));
      LBU:     return s & 32'h0000_00FF;
      LH:      return 32'($signed(s[15:0]));
      LHU:     return s & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] expStore(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] old, input logic [31:0] d);
    logic [31:0] mask;
    case (f3)
      SB:      mask = 32'h0000_00FF << (8 * off);
      SH:      mask = 32'h0000_FFFF << (8 * off);
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old & ~mask) | ((d << (8 * off)) & mask);
  endfunction

  // Starts in IDLE (or in the previous done cycle when chained); returns in
  // the done cycle with req still high.
  task automatic doOp(input logic chained, input logic st, input logic [2:0] f3,
                      input logic [7:0] addr, input logic [31:0] d, input string name);
    logic       ill;
    int         lat, expLat, rd0, wr0, expRd, expWr;
    logic [5:0] wa;
    wa  = addr[7:2];
    ill = illegalOp(st, f3, addr[1:0]);
    isStore = st; funct3 = f3; byteAddr = addr; storeData = d; req = 1'b1;
    if (chained) begin
      @(posedge clock); #1;
    end
    rd0 = rdCnt; wr0 = wrCnt;
    lat = 0;
    while (lat < 10) begin
      @(posedge clock); #1;
      lat++;
      if (done) break;
    end
    expLat = ill ? 1 : ((st && f3 != SW) ? 3 : 2);
    expRd  = ill ? 0 : ((!st || f3 != SW) ? 1 : 0);
    expWr  = (ill || !st) ? 0 : 1;
    chkb({name, "/done"}, done, 1'b1);
    chk({name, "/latency"}, lat, expLat);
    chkb({name, "/fault"}, fault, ill);
    chk({name, "/memReadCycles"}, rdCnt - rd0, expRd);
    chk({name, "/memWriteCycles"}, wrCnt - wr0, expWr);
    if (!st && !ill) modelLoad = expLoad(f3, addr[1:0], refMem[wa]);
    if (st && !ill)  refMem[wa] = expStore(f3, addr[1:0], refMem[wa], d);
    chk({name, "/loadData"}, loadData, modelLoad);
    chk({name, "/memWord"}, mem[wa], refMem[wa]);
  endtask

  task automatic endOp();
    req = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    resetn = 1'b0; req = 1'b0; isStore = 1'b0; funct3 = 3'd0;
    byteAddr = 8'd0; storeData = 32'd0; memLoad = 1'b1;
    for (int i = 0; i < 64; i++) initMem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    initMem[0] = 32'h0000_0000;
    initMem[1] = 32'h8899_AABB;
    initMem[2] = 32'h1122_3344;
    initMem[3] = 32'h5566_7788;
    for (int i = 0; i < 64; i++) refMem[i] = initMem[i];
    repeat (3) @(posedge clock);
    #1;
    chk("rst/loadData", loadData, 32'h0);
    chkb("rst/done", done, 1'b0);
    chkb("rst/fault", fault, 1'b0);
    chkb("rst/memRead", memRead, 1'b0);
    chkb("rst/memWrite", memWrite, 1'b0);
    chk("rst/memAddress", {26'd0, memAddress}, 32'h0);
    chk("rst/memWriteData", memWriteData, 32'h0);
    memLoad = 1'b0;
    resetn  = 1'b1;

    doOp(1'b0, 1'b0, LB,  8'h05, 32'h0, "lb05");  chk("lb05/lit", loadData, 32'hFFFF_FFAA); endOp();
    doOp(1'b0, 1'b0, LHU, 8'h06, 32'h0, "lhu06"); chk("lhu06/lit", loadData, 32'h0000_8899); endOp();
    doOp(1'b0, 1'b0, LH,  8'h06, 32'h0, "lh06");  chk("lh06/lit", loadData, 32'hFFFF_8899); endOp();
    doOp(1'b0, 1'b0, LBU, 8'h07, 32'h0, "lbu07"); chk("lbu07/lit", loadData, 32'h0000_0088); endOp();
    doOp(1'b0, 1'b0, LW,  8'h04, 32'h0, "lw04");  chk("lw04/lit", loadData, 32'h8899_AABB); endOp();
    doOp(1'b0, 1'b1, SB,  8'h09, 32'h0000_00EE, "sb09"); chk("sb09/lit", mem[2], 32'h1122_EE44); endOp();
    doOp(1'b0, 1'b1, SH,  8'h0E, 32'hFFFF_1234, "sh0e"); chk("sh0e/lit", mem[3], 32'h1234_7788); endOp();
    doOp(1'b0, 1'b1, SW,  8'h0E, 32'hDEAD_BEEF, "swMisaligned"); chk("swMisaligned/lit", mem[3], 32'h1234_7788); endOp();
    doOp(1'b0, 1'b0, 3'b011, 8'h10, 32'h0, "ldBadFunct3"); endOp();
    doOp(1'b0, 1'b0, LH,  8'h05, 32'h0, "lhMisaligned"); endOp();
    doOp(1'b0, 1'b1, 3'b100, 8'h10, 32'h1, "stBadFunct3"); endOp();
    doOp(1'b0, 1'b0, LB,  8'h0B, 32'h0, "lb0b"); chk("lb0b/lit", loadData, 32'h0000_0011); endOp();

    doOp(1'b0, 1'b1, SW, 8'h00, 32'hCAFE_F00D, "swChain");
    doOp(1'b1, 1'b0, LW, 8'h00, 32'h0, "lwChain");
    chk("lwChain/lit", loadData, 32'hCAFE_F00D);
    endOp();

    // SH interrupted by reset while in MERGE: memory must be untouched.
    isStore = 1'b1; funct3 = SH; byteAddr = 8'h0C; storeData = 32'h0000_BEEF; req = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chkb("shReset/inMerge", memWrite, 1'b1);
    #1;
    resetn = 1'b0; req = 1'b0; modelLoad = 32'h0;
    #1;
    chk("shReset/loadData", loadData, 32'h0);
    chkb("shReset/done", done, 1'b0);
    chkb("shReset/fault", fault, 1'b0);
    chkb("shReset/memRead", memRead, 1'b0);
    chkb("shReset/memWrite", memWrite, 1'b0);
    chk("shReset/memAddress", {26'd0, memAddress}, 32'h0);
    chk("shReset/memWriteData", memWriteData, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    chk("shReset/mem3", mem[3], 32'h1234_7788);
    resetn = 1'b1;
    doOp(1'b0, 1'b0, LW, 8'h0C, 32'h0, "lwAfterReset"); chk("lwAfterReset/lit", loadData, 32'h1234_7788); endOp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
